// File: rtl/mprj_wb_watchdog.sv
// Registered Wishbone bridge from the management core to the user project, with a
// watchdog that terminates unacknowledged transfers and records sticky timeout status.
module mprj_wb_watchdog #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_dat_o,
  input  logic        mprj_wb_iena,
  output logic        usr_cyc_o,
  output logic        usr_stb_o,
  output logic        usr_we_o,
  output logic [3:0]  usr_sel_o,
  output logic [31:0] usr_adr_o,
  output logic [31:0] usr_dat_o,
  input  logic        usr_ack_i,
  input  logic [31:0] usr_dat_i,
  input  logic        wdt_clear_i,
  output logic        wdt_flag_o,
  output logic [7:0]  wdt_count_o,
  output logic [31:0] wdt_adr_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic        w_start;
  logic        w_abort;
  logic        w_usr_ack;
  logic        w_timeout;

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_usr_ack   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cpu_cyc_i && cpu_stb_i) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Master abort outranks a user ack, and a user ack outranks the timeout.
        if (!cpu_cyc_i) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (usr_ack_i && mprj_wb_iena) begin
          w_usr_ack   = 1'b1;
          w_state_nxt = ST_ACK;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt <= '0;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // User-side request; the async reset drops cyc/stb immediately on a mid-transfer reset.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      usr_cyc_o <= 1'b0;
      usr_stb_o <= 1'b0;
      usr_we_o  <= 1'b0;
      usr_sel_o <= '0;
      usr_adr_o <= '0;
      usr_dat_o <= '0;
    end else if (w_start) begin
      usr_cyc_o <= 1'b1;
      usr_stb_o <= 1'b1;
      usr_we_o  <= cpu_we_i;
      usr_sel_o <= cpu_sel_i;
      usr_adr_o <= cpu_adr_i;
      usr_dat_o <= cpu_dat_i;
    end else if (w_abort || w_usr_ack || w_timeout) begin
      usr_cyc_o <= 1'b0;
      usr_stb_o <= 1'b0;
    end
  end

  // Read data returned to the CPU: user data on ack (also for writes), ERR_DATA on timeout.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cpu_dat_o <= '0;
    end else if (w_usr_ack) begin
      cpu_dat_o <= usr_dat_i;
    end else if (w_timeout) begin
      cpu_dat_o <= ERR_DATA;
    end
  end

  assign cpu_ack_o = (r_state == ST_ACK);

  // A timeout on the same edge as a clear wins, leaving exactly one recorded event.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      wdt_flag_o  <= 1'b0;
      wdt_count_o <= '0;
      wdt_adr_o   <= '0;
    end else if (w_timeout) begin
      wdt_flag_o <= 1'b1;
      wdt_adr_o  <= usr_adr_o;
      if (wdt_clear_i) begin
        wdt_count_o <= 8'd1;
      end else if (wdt_count_o != 8'hFF) begin
        wdt_count_o <= wdt_count_o + 8'd1;
      end
    end else if (wdt_clear_i) begin
      wdt_flag_o  <= 1'b0;
      wdt_count_o <= '0;
    end
  end

endmodule

// File: tb/tb_mprj_wb_watchdog.sv
// Scoreboard bench for mprj_wb_watchdog: stimulus pushes expected CPU responses,
// a monitor pops them on every cpu_ack_o, and a user-side responder checks the request.
module tb_mprj_wb_watchdog;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        core_clk;
  logic        core_rstn;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i;
  logic        cpu_ack_o;
  logic [31:0] cpu_dat_o;
  logic        mprj_wb_iena;
  logic        usr_cyc_o, usr_stb_o, usr_we_o;
  logic [3:0]  usr_sel_o;
  logic [31:0] usr_adr_o, usr_dat_o;
  logic        usr_ack_i;
  logic [31:0] usr_dat_i;
  logic        wdt_clear_i;
  logic        wdt_flag_o;
  logic [7:0]  wdt_count_o;
  logic [31:0] wdt_adr_o;

  mprj_wb_watchdog #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .core_clk    (core_clk),
    .core_rstn   (core_rstn),
    .cpu_cyc_i   (cpu_cyc_i),
    .cpu_stb_i   (cpu_stb_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_adr_i   (cpu_adr_i),
    .cpu_dat_i   (cpu_dat_i),
    .cpu_ack_o   (cpu_ack_o),
    .cpu_dat_o   (cpu_dat_o),
    .mprj_wb_iena(mprj_wb_iena),
    .usr_cyc_o   (usr_cyc_o),
    .usr_stb_o   (usr_stb_o),
    .usr_we_o    (usr_we_o),
    .usr_sel_o   (usr_sel_o),
    .usr_adr_o   (usr_adr_o),
    .usr_dat_o   (usr_dat_o),
    .usr_ack_i   (usr_ack_i),
    .usr_dat_i   (usr_dat_i),
    .wdt_clear_i (wdt_clear_i),
    .wdt_flag_o  (wdt_flag_o),
    .wdt_count_o (wdt_count_o),
    .wdt_adr_o   (wdt_adr_o)
  );

  typedef struct {
    logic [31:0] dat;
    int          cyc;
    logic        flag;
    logic [7:0]  count;
    logic [31:0] adr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_n   = 0;

  // Reference status model, updated by the stimulus as each transfer is issued.
  logic        m_flag  = 1'b0;
  logic [7:0]  m_count = 8'd0;
  logic [31:0] m_adr   = 32'd0;

  // User responder controls and expectations for the request in flight.
  int          ack_at  = 0;
  logic        ack_all = 1'b0;
  logic [31:0] rsp_dat = 32'd0;
  logic        exp_we  = 1'b0;
  logic [3:0]  exp_sel = 4'd0;
  logic [31:0] exp_adr = 32'd0;
  logic [31:0] exp_wd  = 32'd0;
  int          exp_len = 0;
  int          stb_cycles = 0;
  logic        prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_n);
  endtask

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc_n++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  // Monitor: every CPU ack must match the oldest expected response.
  always @(negedge core_clk) begin
    if (core_rstn) begin
      check("ack_with_stb", {31'd0, cpu_ack_o & usr_stb_o}, 32'd0);
      check("ack_twice", {31'd0, cpu_ack_o & prev_ack}, 32'd0);
      prev_ack = cpu_ack_o;
      if (cpu_ack_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cpu_dat", cpu_dat_o, e.dat);
          check("ack_cycle", cyc_n, e.cyc);
          check("wdt_flag", {31'd0, wdt_flag_o}, {31'd0, e.flag});
          check("wdt_count", {24'd0, wdt_count_o}, {24'd0, e.count});
          check("wdt_adr", wdt_adr_o, e.adr);
        end
      end
    end else begin
      prev_ack = 1'b0;
    end
  end

  // User responder: acks on a chosen strobe cycle and checks the forwarded request.
  always @(negedge core_clk) begin
    if (usr_stb_o) begin
      stb_cycles++;
      check("usr_cyc", {31'd0, usr_cyc_o}, 32'd1);
      check("usr_we", {31'd0, usr_we_o}, {31'd0, exp_we});
      check("usr_sel", {28'd0, usr_sel_o}, {28'd0, exp_sel});
      check("usr_adr", usr_adr_o, exp_adr);
      check("usr_dat", usr_dat_o, exp_wd);
      usr_ack_i = ack_all || (stb_cycles == ack_at);
      usr_dat_i = rsp_dat;
    end else begin
      if (stb_cycles != 0) begin
        check("stb_length", stb_cycles, exp_len);
        stb_cycles = 0;
      end
      usr_ack_i = ack_all;
      usr_dat_i = $urandom;
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int a_at, input logic iena,
                      input logic a_all, input logic clr_to, input int abort_at);
    int   k;
    int   c0;
    int   ab;
    logic tmo;
    logic clr;
    logic done;
    exp_t e;
    k   = !iena ? 0 : (a_all ? 1 : a_at);
    tmo = (k == 0) || (k > int'(TMO));
    if (tmo) k = TMO;
    ab  = (abort_at > 0 && abort_at <= k) ? abort_at : 0;
    clr = clr_to && tmo && (ab == 0);
    @(negedge core_clk);
    c0      = cyc_n;
    ack_at  = a_at;
    ack_all = a_all;
    rsp_dat = $urandom;
    exp_we  = we;
    exp_sel = sel;
    exp_adr = adr;
    exp_wd  = dat;
    if (ab > 0) begin
      exp_len = ab;
    end else begin
      exp_len = k;
      if (tmo) begin
        m_flag  = 1'b1;
        m_count = clr ? 8'd1 : ((m_count == 8'hFF) ? 8'hFF : m_count + 8'd1);
        m_adr   = adr;
      end
      e.dat   = tmo ? ERR : rsp_dat;
      e.cyc   = c0 + 1 + k;
      e.flag  = m_flag;
      e.count = m_count;
      e.adr   = m_adr;
      exp_q.push_back(e);
    end
    mprj_wb_iena = iena;
    cpu_cyc_i = 1'b1;
    cpu_stb_i = 1'b1;
    cpu_we_i  = we;
    cpu_sel_i = sel;
    cpu_adr_i = adr;
    cpu_dat_i = dat;
    done = 1'b0;
    for (int i = 1; i <= int'(TMO) + 10; i++) begin
      @(negedge core_clk);
      if (ab > 0 && i == ab) begin
        done = 1'b1;
        break;
      end
      if (cpu_ack_o) begin
        done = 1'b1;
        break;
      end
      wdt_clear_i = clr && (i == int'(TMO));
    end
    if (!done) check("ack_wait", 32'd0, 32'd1);
    wdt_clear_i = 1'b0;
    cpu_cyc_i   = 1'b0;
    cpu_stb_i   = 1'b0;
    if (ab > 0) @(negedge core_clk);
  endtask

  task automatic clear_only();
    @(negedge core_clk);
    wdt_clear_i = 1'b1;
    @(negedge core_clk);
    wdt_clear_i = 1'b0;
    m_flag  = 1'b0;
    m_count = 8'd0;
    check("clr_flag", {31'd0, wdt_flag_o}, {31'd0, m_flag});
    check("clr_count", {24'd0, wdt_count_o}, {24'd0, m_count});
    check("clr_adr_kept", wdt_adr_o, m_adr);
  endtask

  task automatic reset_mid();
    @(negedge core_clk);
    ack_at  = 0;
    ack_all = 1'b0;
    exp_we  = 1'b0;
    exp_sel = 4'hF;
    exp_adr = 32'h3000_0100;
    exp_wd  = 32'h0;
    exp_len = 2;
    mprj_wb_iena = 1'b1;
    cpu_cyc_i = 1'b1;
    cpu_stb_i = 1'b1;
    cpu_we_i  = 1'b0;
    cpu_sel_i = 4'hF;
    cpu_adr_i = 32'h3000_0100;
    cpu_dat_i = 32'h0;
    repeat (2) @(negedge core_clk);
    #1 core_rstn = 1'b0;
    #1;
    check("rst_usr_stb", {31'd0, usr_stb_o}, 32'd0);
    check("rst_usr_cyc", {31'd0, usr_cyc_o}, 32'd0);
    check("rst_cpu_ack", {31'd0, cpu_ack_o}, 32'd0);
    cpu_cyc_i = 1'b0;
    cpu_stb_i = 1'b0;
    m_flag  = 1'b0;
    m_count = 8'd0;
    m_adr   = 32'd0;
    #1 core_rstn = 1'b1;
    repeat (3) @(negedge core_clk);
    check("rst_wdt_flag", {31'd0, wdt_flag_o}, 32'd0);
  endtask

  initial begin
    core_rstn    = 1'b0;
    cpu_cyc_i    = 1'b0;
    cpu_stb_i    = 1'b0;
    cpu_we_i     = 1'b0;
    cpu_sel_i    = 4'd0;
    cpu_adr_i    = 32'd0;
    cpu_dat_i    = 32'd0;
    mprj_wb_iena = 1'b1;
    wdt_clear_i  = 1'b0;
    #1;
    check("rst_cpu_ack0", {31'd0, cpu_ack_o}, 32'd0);
    check("rst_cpu_dat0", cpu_dat_o, 32'd0);
    check("rst_usr_ctl0", {29'd0, usr_cyc_o, usr_stb_o, usr_we_o}, 32'd0);
    check("rst_usr_sel0", {28'd0, usr_sel_o}, 32'd0);
    check("rst_usr_adr0", usr_adr_o, 32'd0);
    check("rst_usr_dat0", usr_dat_o, 32'd0);
    check("rst_wdt0", {23'd0, wdt_flag_o, wdt_count_o}, 32'd0);
    check("rst_wdt_adr0", wdt_adr_o, 32'd0);
    repeat (2) @(negedge core_clk);
    core_rstn = 1'b1;

    // Read acked in the 2nd strobe cycle, then the directed write.
    xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0, 2, 1'b1, 1'b0, 1'b0, 0);
    xfer(1'b1, 32'h3000_0004, 4'b0011, 32'hA5A5_0F0F, 1, 1'b1, 1'b0, 1'b0, 0);
    @(negedge core_clk);
    check("usr_dat_hold", usr_dat_o, 32'hA5A5_0F0F);

    // Timeout, ack on the final strobe cycle, clear alone, clear racing a timeout.
    xfer(1'b0, 32'h3000_0040, 4'hF, 32'h0, 0, 1'b1, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'h3000_0044, 4'hF, 32'h0, TMO, 1'b1, 1'b0, 1'b0, 0);
    xfer(1'b0, 32'h3000_0048, 4'hF, 32'h0, 0, 1'b1, 1'b0, 1'b0, 0);
    clear_only();
    xfer(1'b0, 32'h3000_004C, 4'hF, 32'h0, 0, 1'b1, 1'b0, 1'b0, 0);
    xfer(1'b1, 32'h3000_0050, 4'h1, 32'h77, 0, 1'b1, 1'b0, 1'b1, 0);

    // Master abort on the 3rd REQ cycle and a mid-REQ reset, each followed by a normal transfer.
    xfer(1'b0, 32'h3000_0060, 4'hF, 32'h0, 0, 1'b1, 1'b0, 1'b0, 3);
    xfer(1'b0, 32'h3000_0064, 4'hF, 32'h0, 3, 1'b1, 1'b0, 1'b0, 0);
    reset_mid();
    xfer(1'b1, 32'h3000_0068, 4'hC, 32'h1234_0000, 1, 1'b1, 1'b0, 1'b0, 0);

    // Return path disabled while the user acks every cycle: 300 timeouts saturate the count.
    for (int n = 0; n < 300; n++) begin
      xfer(1'b0, 32'h3100_0000 + 32'(n), 4'hF, 32'h0, 1, 1'b0, 1'b1, 1'b0, 0);
    end
    ack_all = 1'b0;
    check("count_saturated", {24'd0, wdt_count_o}, 32'd255);
    clear_only();

    for (int n = 0; n < 80; n++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom,
           int'($urandom_range(0, TMO + 2)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TMO)) : 0);
    end
    ack_all = 1'b0;

    repeat (4) @(negedge core_clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mprj_wb_watchdog.md
# mprj_wb_watchdog

Registered Wishbone bridge between the management core's exported user-project bus and the user project. It forwards each classic single-beat CPU transfer to the user area and returns the user's acknowledge and read data. If the user never acknowledges, it terminates the transfer itself after a programmable number of cycles, so an absent or hung user design cannot stall the CPU. It also records sticky timeout status for housekeeping.

## Interface
Parameters:
- TIMEOUT, 1024: cycles the user-side strobe stays high before forced termination; legal range 2..65535.
- ERR_DATA, 32'hFFFF_FFFF: read data returned on a timed-out transfer.

Ports:
- core_clk  in  1  sole clock; all state changes on rising edge
- core_rstn  in  1  asynchronous active-low reset
- cpu_cyc_i, cpu_stb_i, cpu_we_i  in  1  CPU-side Wishbone controls (from management core mprj_*_o)
- cpu_sel_i  in  4  byte selects
- cpu_adr_i, cpu_dat_i  in  32  address, write data
- cpu_ack_o  out  1  one-cycle acknowledge to CPU
- cpu_dat_o  out  32  read data to CPU
- mprj_wb_iena  in  1  user return-path enable; when low, usr_ack_i and usr_dat_i are ignored
- usr_cyc_o, usr_stb_o, usr_we_o  out  1  user-side controls, registered
- usr_sel_o  out  4; usr_adr_o, usr_dat_o  out  32  registered copies of the request
- usr_ack_i  in  1; usr_dat_i  in  32  user-side response
- wdt_clear_i  in  1  synchronous clear of status
- wdt_flag_o  out  1  sticky: at least one timeout occurred
- wdt_count_o  out  8  number of timeouts, saturating at 255
- wdt_adr_o  out  32  address of the most recent timed-out transfer

## Operation
- FSM states: IDLE, REQ, ACK.
- IDLE: on a clock edge with cpu_cyc_i&cpu_stb_i:
  - latch we/sel/adr/dat into the usr_* registers;
  - set usr_cyc_o=usr_stb_o=1;
  - clear the 16-bit counter to 0;
  - go to REQ.
- REQ, evaluated each edge in this priority order:
  - cpu_cyc_i=0 (master abort): drop usr_cyc_o/usr_stb_o; go to IDLE; no cpu_ack_o; status unchanged.
  - usr_ack_i&mprj_wb_iena: cpu_dat_o<=usr_dat_i (including on writes); drop usr lines; go to ACK.
  - counter==TIMEOUT-1: cpu_dat_o<=ERR_DATA; drop usr lines; go to ACK.
    - set wdt_flag_o; increment wdt_count_o, saturating at 255; wdt_adr_o<=usr_adr_o.
  - otherwise: counter+1.
- ACK: cpu_ack_o=1 for exactly this cycle; go to IDLE unconditionally.
- usr_ack_i outside REQ is ignored. usr_dat_o holds its last value between transfers.
- wdt_clear_i: clears wdt_flag_o and wdt_count_o. wdt_adr_o is not cleared.
  - If a timeout is recorded on the same edge, the timeout wins: flag=1, count=1.
- Reset values: every output is 0 (cpu_dat_o, usr_*, wdt_*); state IDLE; counter 0.
- Reset asserted mid-transfer: usr_cyc_o/usr_stb_o drop immediately (asynchronously); no ack is issued.

## Timing
- Request sampled at edge E0 → usr_stb_o high in the cycle after E0.
- User ack sampled at edge Ek → cpu_ack_o high in the cycle after Ek, with data valid in that same cycle.
- Minimum CPU-visible latency is 3 cycles, stb to ack sampled; bridge overhead is 2 cycles over the user's latency.
- Timeout: usr_stb_o is high for exactly TIMEOUT cycles. An ack sampled on the final cycle wins over the timeout (no status update).
- Back-to-back transfers: a new request may be accepted at the first edge after ACK. IDLE lasts at least 1 cycle between transfers.
- cpu_ack_o is never high for 2 consecutive cycles. cpu_ack_o and usr_stb_o are never both high.

## Test plan
- Read, user acks in its 2nd stb cycle with usr_dat_i=32'h1234_5678 → one cpu_ack_o pulse with cpu_dat_o=32'h1234_5678, 4 cycles after CPU stb; wdt_flag_o stays 0.
- Write, adr 32'h3000_0004, sel 4'b0011, dat 32'hA5A5_0F0F → usr_* outputs carry exactly these values while usr_stb_o is high; single cpu_ack_o pulse.
- TIMEOUT=8, user never acks → usr_stb_o high for 8 cycles, then cpu_ack_o with cpu_dat_o=ERR_DATA; wdt_flag_o=1, wdt_count_o=1, wdt_adr_o=request address.
- mprj_wb_iena=0 with user acking every cycle → timeout path taken, as in the previous scenario; 300 such timeouts → wdt_count_o=255.
- wdt_clear_i asserted on the same edge as a timeout → wdt_flag_o=1, wdt_count_o=1. Clear alone → flag 0, count 0, wdt_adr_o unchanged.
- cpu_cyc_i dropped on the 3rd REQ cycle, and separately core_rstn pulsed mid-REQ → usr lines drop, no cpu_ack_o. The next request completes normally.
